// File: rtl/jtcps1_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | jtcps1_sched_pkg: shared types and constants for the CPS1 SDRAM scheduler  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package jtcps1_sched_pkg;

  localparam int C_SCHED_SLOTS = 4;
  localparam int C_SCHED_AW    = 22;

  // A single-slot build still needs a one-bit grant index
  function automatic int gnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int C_SCHED_GW = gnt_width(C_SCHED_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/jtcps1_sdram_sched_if.sv
// +----------------------------------------------------------------------------+
// | jtcps1_sdram_sched_if: scheduler <-> SDRAM controller handshake bundle     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface jtcps1_sdram_sched_if
  import jtcps1_sched_pkg::*;
#(
  parameter int AW = C_SCHED_AW
);
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_rnw;
  logic [1:0]    sdram_wrmask;
  logic [15:0]   data_write;
  logic          refresh_en;
  logic          sdram_ack;
  logic          data_rdy;
  logic [31:0]   data_read;

  modport master (
    output sdram_req, sdram_addr, sdram_rnw, sdram_wrmask, data_write, refresh_en,
    input  sdram_ack, data_rdy, data_read
  );

  modport slave (
    input  sdram_req, sdram_addr, sdram_rnw, sdram_wrmask, data_write, refresh_en,
    output sdram_ack, data_rdy, data_read
  );
endinterface

`default_nettype wire

// File: rtl/jtcps1_rr_pick.sv
// +----------------------------------------------------------------------------+
// | jtcps1_rr_pick: combinational rotating-priority picker                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module jtcps1_rr_pick
  import jtcps1_sched_pkg::*;
#(
  parameter int N = C_SCHED_SLOTS,
  parameter int W = gnt_width(N)
) (
  input  wire logic [N-1:0] i_req,
  input  wire logic [W-1:0] i_start,
  output logic              o_valid,
  output logic [W-1:0]      o_idx
);

  logic         w_found;
  logic [W-1:0] w_idx;
  int           w_k;

  // Walk i_start, i_start+1, ... wrapping at N; first set request wins
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_k     = 0;
    for (int i = 0; i < N; i++) begin
      w_k = int'(i_start) + i;
      if (w_k >= N) w_k = w_k - N;
      if (!w_found && ((i_req >> w_k) & N'(1)) != '0) begin
        w_found = 1'b1;
        w_idx   = W'(w_k);
      end
    end
  end

  assign o_valid = w_found;
  assign o_idx   = w_idx;

endmodule

`default_nettype wire

// File: rtl/jtcps1_sdram_sched.sv
// +----------------------------------------------------------------------------+
// | jtcps1_sdram_sched: round-robin SDRAM request scheduler for CPS1 clients   |
// | Optional macro JTCPS1_SCHED_CPUPRIO_EN gives slot 0 fixed top priority.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module jtcps1_sdram_sched
  import jtcps1_sched_pkg::*;
#(
  parameter int SLOTS = C_SCHED_SLOTS,
  parameter int AW    = C_SCHED_AW
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  downloading,
  input  wire logic [SLOTS-1:0]      slot_req,
  input  wire logic [SLOTS*AW-1:0]   slot_addr,
  input  wire logic                  slot0_wr,
  input  wire logic [15:0]           slot0_din,
  input  wire logic [1:0]            slot0_wrmask,
  output logic      [SLOTS-1:0]      slot_ok,
  output logic      [31:0]           slot_dout,
  jtcps1_sdram_sched_if.master       sd
);

  localparam int            GW         = gnt_width(SLOTS);
  localparam logic [GW-1:0] C_LAST_RST = GW'(SLOTS - 1);

  sched_state_t  r_state;
  logic [GW-1:0] r_gnt;
  logic [GW-1:0] r_last;
  logic          r_sdram_req;
  logic [AW-1:0] r_addr;
  logic          r_rnw;
  logic [1:0]    r_wrmask;
  logic [15:0]   r_wdata;
  logic          r_refresh;

  logic [GW-1:0]    w_start;
  logic [SLOTS-1:0] w_pick_req;
  logic             w_pick_valid;
  logic [GW-1:0]    w_pick_idx;
  logic             w_win_valid;
  logic [GW-1:0]    w_win_idx;
  logic [AW-1:0]    w_win_addr;
  logic             w_grant;
  logic             w_done;
  logic             w_to_idle;

  assign w_start = (r_last == C_LAST_RST) ? '0 : r_last + GW'(1);

`ifdef JTCPS1_SCHED_CPUPRIO_EN
  // Slot 0 bypasses the rotation; the picker only sees slots 1..SLOTS-1
  assign w_pick_req  = slot_req & ~SLOTS'(1);
  assign w_win_valid = slot_req[0] | w_pick_valid;
  assign w_win_idx   = slot_req[0] ? '0 : w_pick_idx;
`else
  assign w_pick_req  = slot_req;
  assign w_win_valid = w_pick_valid;
  assign w_win_idx   = w_pick_idx;
`endif

  jtcps1_rr_pick #(
    .N (SLOTS),
    .W (GW)
  ) u_pick (
    .i_req   (w_pick_req),
    .i_start (w_start),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_win_addr = AW'(slot_addr >> (int'(w_win_idx) * AW));

  assign w_grant   = (r_state == ST_IDLE) && !downloading && w_win_valid;
  // Ack and data_rdy together in REQ complete immediately, skipping DATA
  assign w_done    = ((r_state == ST_REQ)  && sd.sdram_ack && sd.data_rdy) ||
                     ((r_state == ST_DATA) && sd.data_rdy);
  assign w_to_idle = ((r_state == ST_IDLE) && !w_grant) || w_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_last      <= C_LAST_RST;
      r_sdram_req <= 1'b0;
      r_addr      <= '0;
      r_rnw       <= 1'b1;
      r_wrmask    <= 2'b11;
      r_wdata     <= '0;
      r_refresh   <= 1'b0;
      slot_ok     <= '0;
      slot_dout   <= '0;
    end else begin
      slot_ok   <= '0;
      r_refresh <= downloading | (w_to_idle & ~|slot_req);

      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state     <= ST_REQ;
            r_sdram_req <= 1'b1;
            r_gnt       <= w_win_idx;
            r_addr      <= w_win_addr;
            r_wdata     <= slot0_din;
            if (w_win_idx == '0) begin
              r_rnw    <= ~slot0_wr;
              r_wrmask <= slot0_wrmask;
            end else begin
              r_rnw    <= 1'b1;
              r_wrmask <= 2'b11;
            end
          end
        end
        ST_REQ: begin
          if (sd.sdram_ack) begin
            r_sdram_req <= 1'b0;
            r_state     <= ST_DATA;
          end
        end
        ST_DATA: ;
        default: r_state <= ST_IDLE;
      endcase

      if (w_done) begin
        r_state   <= ST_IDLE;
        slot_dout <= sd.data_read;
        slot_ok   <= SLOTS'(1) << r_gnt;
`ifdef JTCPS1_SCHED_CPUPRIO_EN
        if (r_gnt != '0) r_last <= r_gnt;
`else
        r_last <= r_gnt;
`endif
      end
    end
  end

  assign sd.sdram_req    = r_sdram_req;
  assign sd.sdram_addr   = r_addr;
  assign sd.sdram_rnw    = r_rnw;
  assign sd.sdram_wrmask = r_wrmask;
  assign sd.data_write   = r_wdata;
  assign sd.refresh_en   = r_refresh;

endmodule

`default_nettype wire

// File: doc/jtcps1_sdram_sched.md
# jtcps1_sdram_sched

Request scheduler placed between the CPS1 memory clients (main CPU ROM, CPU RAM/VRAM, GFX ROM fetchers and VRAM readers) and the single-port SDRAM controller. It accepts independent per-slot read requests plus one read/write slot. It grants the SDRAM to one slot at a time by round-robin and sequences the req/ack/data_rdy handshake. It returns read data with a one-cycle `slot_ok` pulse to the granted slot, and holds all traffic off while ROM download is active.

## Interface
Parameters:
- `SLOTS`, 4 — number of requesters; slot 0 is the only one allowed to write.
- `AW`, 22 — SDRAM word address width.

Ports:
- `clk` in 1 — system clock.
- `rst` in 1 — asynchronous reset, active-high.
- `downloading` in 1 — ROM load in progress; blocks new grants.
- `slot_req` in SLOTS — per-slot request level; hold high until `slot_ok`.
- `slot_addr` in SLOTS*AW — flattened addresses; slot i at bits [i*AW +: AW].
- `slot0_wr` in 1 — slot 0 request is a write.
- `slot0_din` in 16 — slot 0 write data.
- `slot0_wrmask` in 2 — byte mask, active-low enable.
- `slot_ok` out SLOTS — one-cycle completion pulse, one-hot.
- `slot_dout` out 32 — read data; valid in the `slot_ok` cycle.
- `sdram_req` out 1 — request to the controller.
- `sdram_addr` out AW — latched address.
- `sdram_rnw` out 1 — 1 for read, 0 for write.
- `sdram_wrmask` out 2 — latched mask.
- `data_write` out 16 — latched write data.
- `sdram_ack` in 1 — controller accepted the request.
- `data_rdy` in 1 — read data valid, or write done.
- `data_read` in 32 — SDRAM read data.
- `refresh_en` out 1 — controller may refresh.

## Operation
- The state machine has three states: IDLE, REQ and DATA.
- IDLE:
  - Go to REQ when `downloading`=0 and any `slot_req` is set.
  - Pick the winner with the rotating-priority search. The search starts at `last+1` mod SLOTS, where `last` is the most recently serviced slot (reset value SLOTS-1, so slot 0 wins first).
  - On the transition, latch `sdram_addr`, `sdram_rnw` (`~slot0_wr` for slot 0, 1 for every other slot), `sdram_wrmask`, `data_write` and the grant index.
- REQ: `sdram_req`=1. When `sdram_ack`=1, drop `sdram_req` and go to DATA.
- DATA: when `data_rdy`=1:
  - Register `data_read` into `slot_dout`.
  - Pulse `slot_ok[gnt]`.
  - Set `last`=gnt and return to IDLE.
- Writes from slot 0 complete the same way. `slot_dout` is updated on writes but carries no meaning.
- `refresh_en`=1 only in IDLE with no request pending, or whenever `downloading`=1.
- If a slot drops `slot_req` after it has been granted, the transaction still completes and the `slot_ok` pulse is still issued.
- Latched values do not change between grant and `slot_ok`, even if slot inputs change.
- `downloading` rising mid-transaction does not abort it. The current access completes; no new grant follows.
- Address and mask pass through unmodified. Offset addition belongs to the clients.

## Timing
- Reset values:
  - state IDLE, `last`=SLOTS-1.
  - `sdram_req`, `slot_ok`, `slot_dout`, `sdram_addr`, `data_write` = 0.
  - `sdram_rnw`=1, `sdram_wrmask`=2'b11, `refresh_en`=0.
- Request at edge N (IDLE) gives `sdram_req`=1 from edge N+1.
- `sdram_ack` at edge M gives `sdram_req`=0 from edge M+1.
- `data_rdy` at edge K gives `slot_ok` and `slot_dout` valid during the cycle after edge K+1.
- Back-to-back: the next grant can be taken in the IDLE cycle following `slot_ok`. Minimum turnaround per access is 3 cycles plus controller latency.
- `sdram_ack` and `data_rdy` arriving in the same cycle while in REQ: go directly to completion, as if DATA had been visited.
- `data_rdy` while in IDLE or REQ without a prior ack is ignored.

## Configuration
- `JTCPS1_SCHED_CPUPRIO_EN`:
  - Defined: slot 0 has fixed top priority. It wins whenever its request is set in IDLE, and the rotating search applies only among slots 1..SLOTS-1. `last` is not updated by slot 0 services.
  - Undefined: pure round-robin over all slots.

## Structure
- Package `jtcps1_sched_pkg` holds:
  - the state encoding (IDLE=0, REQ=1, DATA=2);
  - default SLOTS and AW;
  - a `clog2`-based grant-index width constant.
- Sub-module `jtcps1_rr_pick`: combinational rotating-priority picker. Inputs are the request vector and the start index; outputs are a valid flag and the winner index. It is instantiated once.

## Test plan
- Reset: assert `rst` mid-DATA → all outputs return immediately to reset values; the next request from slot 2 is granted normally.
- Fairness: slots 0-3 all held high, ack/data_rdy after 2 cycles → `slot_ok` order 0,1,2,3,0,1,…; no slot serviced twice in any 4 consecutive completions.
- Write: slot 0, `slot0_wr`=1, `slot0_din`=16'hBEEF, mask 2'b10 → `sdram_rnw`=0, `data_write`=BEEF, `sdram_wrmask`=2'b10; `slot_ok[0]` after `data_rdy`.
- Download: `downloading`=1 while slot 1 requests → `sdram_req` stays 0 and `refresh_en`=1; after release, slot 1 gets `slot_dout`=`data_read` (32'h12345678).
- Coincident handshake: `sdram_ack` and `data_rdy` in the same cycle → single `slot_ok` pulse one cycle later; no hang.
- Macro on: slots 0 and 3 requesting continuously → slot 0 wins every arbitration and slot 3 only when slot 0 is idle; macro off → strict alternation 0,3,0,3.
